// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// and reports difference, borrow-out and signed overflow with a valid pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             valid
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic             x_s, y_s, d_s, br_nxt_s;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            diff_q  <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Full-subtractor cell on the current LSBs, next-state and output logic
    always_comb begin
        x_s      = a_q[0];
        y_s      = b_q[0];
        d_s      = x_s ^ y_s ^ br_q;
        br_nxt_s = (~x_s & y_s) | (~(x_s ^ y_s) & br_q);

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                diff_d = {d_s, diff_q[WIDTH-1:1]};
                br_d   = br_nxt_s;
                cnt_d  = cnt_q + CNT_ONE;
                // On the last bit x_s/y_s are the operand MSBs and d_s is diff's MSB
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    bout_d  = br_nxt_s;
                    ovf_d   = (x_s ^ y_s) & (x_s ^ d_s);
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign diff  = diff_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) using a result queue
// filled at launch time and drained when valid is observed.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         busy;
    logic         valid;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf),
        .busy  (busy),
        .valid (valid)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        exp_t       e;
        logic [W:0] full;
        full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        e.d  = full[W-1:0];
        e.bo = full[W];
        e.ov = (ma[W-1] ^ mb[W-1]) & (ma[W-1] ^ full[W-1]);
        return e;
    endfunction

    // Drive one start pulse; returns at the negedge right after the accepting edge.
    task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb, input logic lbin);
        @(negedge clk);
        start = 1'b1;
        a     = la;
        b     = lb;
        bin   = lbin;
        exp_q.push_back(model(la, lb, lbin));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for the result of the operation launched one edge ago and check it.
    task automatic collect(input string name, input int glitch_cyc, input int rst_cyc,
                           input logic chain, input logic [W-1:0] na, input logic [W-1:0] nb,
                           input logic nbin);
        int   lat;
        bit   got;
        bit   aborted;
        exp_t e;
        lat = 0; got = 0; aborted = 0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_run: got %b want 1", name, busy);
        end
        while (lat < 20 && !got) begin
            if (valid === 1'b1) begin
                got = 1;
            end else begin
                @(negedge clk);
                lat++;
                if (lat == glitch_cyc) begin
                    start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b0;
                end else if (lat == glitch_cyc + 1) begin
                    start = 1'b0;
                end
                if (lat == rst_cyc) begin
                    rst = 1'b1;
                    #1;
                    total++;
                    if ({diff, bout, ovf, busy, valid} !== '0) begin
                        bad++;
                        $display("FAIL %s rst_abort: got diff=%h bout=%b ovf=%b busy=%b valid=%b want all 0",
                                 name, diff, bout, ovf, busy, valid);
                    end
                    aborted = 1;
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    @(negedge clk);
                    rst = 1'b0;
                    lat++;
                end
            end
        end
        if (aborted) begin
            total++;
            if (got) begin
                bad++;
                $display("FAIL %s no_valid_after_rst: got valid=1 want 0", name);
            end
            return;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s timeout: got no valid want valid within 20 cycles", name);
            return;
        end
        total++;
        if (lat != W) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, W);
        end
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard: got valid want empty queue", name);
            return;
        end
        e = exp_q.pop_front();
        if ({diff, bout, ovf} !== {e.d, e.bo, e.ov}) begin
            bad++;
            $display("FAIL %s result: got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                     name, diff, bout, ovf, e.d, e.bo, e.ov);
        end
        if (chain) begin
            start = 1'b1; a = na; b = nb; bin = nbin;
            exp_q.push_back(model(na, nb, nbin));
        end
        @(negedge clk);
        total++;
        if ({valid, busy, diff, bout, ovf} !== {1'b0, 1'b0, e.d, e.bo, e.ov}) begin
            bad++;
            $display("FAIL %s pulse_end_hold: got valid=%b busy=%b diff=%h bout=%b ovf=%b want valid=0 busy=0 diff=%h bout=%b ovf=%b",
                     name, valid, busy, diff, bout, ovf, e.d, e.bo, e.ov);
        end
        if (chain) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({diff, bout, ovf, busy, valid} !== '0) begin
            bad++;
            $display("FAIL reset_state: got diff=%h bout=%b ovf=%b busy=%b valid=%b want all 0",
                     diff, bout, ovf, busy, valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        launch(8'h05, 8'h03, 1'b0); collect("v_5m3",   -1, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        launch(8'h03, 8'h05, 1'b0); collect("v_3m5",   -1, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        launch(8'h00, 8'h00, 1'b1); collect("v_0m0b1", -1, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        launch(8'h80, 8'h01, 1'b0); collect("v_ovf",   -1, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        launch(8'h7F, 8'hFF, 1'b1); collect("v_ovf_neg", -1, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            launch(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            collect("v_rand", -1, -1, 1'b0, 8'h00, 8'h00, 1'b0);
        end
    endtask

    task automatic test_ignore_start();
        launch(8'h40, 8'h11, 1'b1);
        collect("ignore_start", 3, -1, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_rst_abort();
        launch(8'h55, 8'h22, 1'b0);
        collect("rst_abort", -1, 4, 1'b0, 8'h00, 8'h00, 1'b0);
        launch(8'h10, 8'h01, 1'b0);
        collect("after_rst", -1, -1, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        launch(8'hA0, 8'h3C, 1'b0);
        collect("b2b_first", -1, -1, 1'b1, 8'h01, 8'h02, 1'b1);
        collect("b2b_second", -1, -1, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        bin   = 1'b0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_rst_abort();
        test_back_to_back();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
